// File: rtl/sine_sequencer_if.sv
// Bundle of control, table-write, LUT and DAC signals for sine_sequencer.
// Ports: start/stop pulses, cfg_* table write port, lut_addr/lut_data LUT
//   access, dac_code/dac_valid sample output, busy/note_idx/done status.
//   slave = the sequencer side, master = the environment side.

interface sine_sequencer_if #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 10
);
    logic                start;
    logic                stop;
    logic                cfg_we;
    logic [1:0]          cfg_idx;
    logic [PHASE_W-1:0]  cfg_inc;
    logic [15:0]         cfg_len;
    logic [ADDR_W-1:0]   lut_addr;
    logic [DATA_W-2:0]   lut_data;
    logic [DATA_W-1:0]   dac_code;
    logic                dac_valid;
    logic                busy;
    logic [1:0]          note_idx;
    logic                done;

    modport slave (
        input  start, stop, cfg_we, cfg_idx, cfg_inc, cfg_len,
        input  lut_data,
        output lut_addr, dac_code, dac_valid, busy, note_idx, done
    );

    modport master (
        output start, stop, cfg_we, cfg_idx, cfg_inc, cfg_len,
        output lut_data,
        input  lut_addr, dac_code, dac_valid, busy, note_idx, done
    );
endinterface

// File: rtl/sine_sequencer.sv
// Tone-table sequencer: steps a phase accumulator once per sample tick,
// addresses a quarter-wave LUT and folds the magnitude into an
// offset-binary DAC code. Up to four notes (inc, len) play in order.
// Ports: clk, reset (sync, active high), bus (sine_sequencer_if.slave):
//   start/stop, cfg_we/cfg_idx/cfg_inc/cfg_len, lut_addr -> lut_data,
//   dac_code/dac_valid, busy, note_idx, done.
// Build option SINE_SEQ_LOOP_EN: wrap to the first non-empty note after
//   the last one instead of finishing (busy until stop/reset).

module sine_sequencer #(
    parameter int SAMPLE_DIV = 375,
    parameter int PHASE_W    = 16,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 10
) (
    input  logic            clk,
    input  logic            reset,
    sine_sequencer_if.slave bus
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DATA_W-1:0] MID_HI = DATA_W'(1 << (DATA_W - 1));
    localparam logic [DATA_W-1:0] MID_LO = DATA_W'((1 << (DATA_W - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PHASE_W-1:0] tbl_inc [4];
    logic [15:0]        tbl_len [4];

    logic [PHASE_W-1:0] phase;
    logic [DIV_W-1:0]   div_cnt;
    logic [15:0]        remain;
    logic [1:0]         note_q;
    logic               drain;

    logic [1:0]         quad;
    logic [ADDR_W-1:0]  idx;

    logic [ADDR_W-1:0]  addr_q;
    logic               s1_vld;
    logic               s1_neg;
    logic               s2_vld;
    logic               s2_neg;
    logic [DATA_W-1:0]  code_q;
    logic               vld_q;
    logic               done_q;

    logic               first_ok;
    logic [1:0]         first_idx;
    logic               next_ok;
    logic [1:0]         next_idx;

    logic               tick;
    logic               issue;
    logic               go;
    logic               fin_done;

    assign quad = phase[PHASE_W-1 -: 2];
    assign idx  = phase[PHASE_W-3 -: ADDR_W];

    // Lowest-numbered non-empty entry.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (tbl_len[2'(i)] != 16'd0) begin
                first_ok  = 1'b1;
                first_idx = 2'(i);
            end
        end
    end

    // Next non-empty entry after the current note.
    always_comb begin
        next_ok  = 1'b0;
        next_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(note_q) && tbl_len[2'(i)] != 16'd0) begin
                next_ok  = 1'b1;
                next_idx = 2'(i);
            end
        end
`ifdef SINE_SEQ_LOOP_EN
        if (!next_ok) begin
            next_ok  = first_ok;
            next_idx = first_idx;
        end
`endif
    end

    assign tick  = (state == S_PLAY) && (div_cnt == DIV_LAST);
    assign issue = tick && !bus.stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FINISH holds two cycles so the last sample leaves the
    // LUT pipeline in the same cycle that done pulses.
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        fin_done = 1'b0;
        if (bus.stop) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        go       = 1'b1;
                        state_nx = first_ok ? S_PLAY : S_FINISH;
                    end
                end
                S_PLAY: begin
                    if (tick && remain == 16'd1 && !next_ok) begin
                        state_nx = S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (drain) begin
                        state_nx = S_IDLE;
                        fin_done = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tbl_inc[i] <= '0;
                tbl_len[i] <= '0;
            end
            phase   <= '0;
            div_cnt <= '0;
            remain  <= '0;
            note_q  <= '0;
            drain   <= 1'b0;
            addr_q  <= '0;
            s1_vld  <= 1'b0;
            s1_neg  <= 1'b0;
            s2_vld  <= 1'b0;
            s2_neg  <= 1'b0;
            code_q  <= MID_HI;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.cfg_we) begin
                tbl_inc[bus.cfg_idx] <= bus.cfg_inc;
                tbl_len[bus.cfg_idx] <= bus.cfg_len;
            end

            drain <= (state == S_FINISH) && !drain && !bus.stop;

            if (go) begin
                phase   <= '0;
                div_cnt <= '0;
                remain  <= tbl_len[first_idx];
                if (first_ok) begin
                    note_q <= first_idx;
                end
            end else if (state == S_PLAY) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end

            // Odd quadrants walk the quarter wave backwards,
            // the upper half of the cycle is negative.
            if (issue) begin
                addr_q <= quad[0] ? ~idx : idx;
                s1_neg <= quad[1];
                phase  <= phase + tbl_inc[note_q];
                if (remain == 16'd1) begin
                    if (next_ok) begin
                        note_q <= next_idx;
                        remain <= tbl_len[next_idx];
                    end
                end else begin
                    remain <= remain - 16'd1;
                end
            end

            s1_vld <= issue;
            s2_vld <= s1_vld && !bus.stop;
            s2_neg <= s1_neg;
            vld_q  <= s2_vld && !bus.stop;
            done_q <= fin_done;

            if (bus.stop || done_q) begin
                code_q <= MID_HI;
            end else if (s2_vld) begin
                code_q <= s2_neg ? MID_LO - {1'b0, bus.lut_data}
                                 : MID_HI + {1'b0, bus.lut_data};
            end
        end
    end

    assign bus.lut_addr  = addr_q;
    assign bus.dac_code  = code_q;
    assign bus.dac_valid = vld_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.note_idx  = note_q;
    assign bus.done      = done_q;

endmodule
